// File: rtl/lht_pkg.sv
// lht_pkg: shared defaults, update record and controller state for the LHT access controller
package lht_pkg;
  localparam int LHT_IDX_W  = 10;
  localparam int LHT_HIST_W = 10;
  typedef struct packed {
    logic [LHT_IDX_W-1:0] idx;
    logic                 taken;
  } lht_upd_t;
  typedef enum logic [1:0] {CLEAR, IDLE, UPD_WR} lht_ctrl_state_t;
endpackage

// File: rtl/lht_upd_fifo.sv
// lht_upd_fifo: synchronous FIFO of pending LHT updates, flushed by an active-low sync reset
module lht_upd_fifo import lht_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = lht_upd_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/lht_access_ctrl.sv
// lht_access_ctrl: shares the single-port LHT RAM between lookups and queued read-modify-write updates
module lht_access_ctrl import lht_pkg::*; #(
  parameter int IDX_W          = LHT_IDX_W,
  parameter int HIST_W         = LHT_HIST_W,
  parameter int Q_DEPTH        = 4,
  parameter int MAX_STARVE     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     lk_valid_i,
  input  logic [IDX_W-1:0]         lk_idx_i,
  output logic                     lk_ready_o,
  output logic                     lk_hist_valid_o,
  output logic [HIST_W-1:0]        lk_hist_o,
  input  logic                     up_valid_i,
  input  logic [IDX_W-1:0]         up_idx_i,
  input  logic                     up_taken_i,
  output logic                     up_ready_o,
  output logic                     ram_en_o,
  output logic                     ram_we_o,
  output logic [IDX_W-1:0]         ram_addr_o,
  output logic [HIST_W-1:0]        ram_wdata_o,
  input  logic [HIST_W-1:0]        ram_rdata_i,
  output logic [$clog2(Q_DEPTH):0] q_count_o
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;
  lht_ctrl_state_t state_q;
  logic [IDX_W-1:0] clr_q;
  logic [SW-1:0] starve_q;
  upd_t wr_q, head, up_in;
  logic hv_q;
  logic [HIST_W-1:0] hist_q;
  logic full, empty, push, upd_go, lk_go, wr_st;
  assign up_in  = '{idx: up_idx_i, taken: up_taken_i};
  assign upd_go = state_q == IDLE && !empty && (full || !lk_valid_i || starve_q == SW'(MAX_STARVE));
  assign lk_go  = state_q == IDLE && !upd_go && lk_valid_i;
  assign push   = up_valid_i && up_ready_o;
  assign wr_st  = state_q == CLEAR || state_q == UPD_WR;
  // Reset gates every request so nothing reaches the RAM while reset is held
  assign lk_ready_o      = rst_ni && lk_go;
  assign up_ready_o      = rst_ni && state_q != CLEAR && !full;
  assign ram_en_o        = rst_ni && (wr_st || upd_go || lk_go);
  assign ram_we_o        = rst_ni && wr_st;
  assign ram_addr_o      = !ram_en_o ? '0 : state_q == CLEAR ? clr_q : state_q == UPD_WR ? wr_q.idx :
                           upd_go ? head.idx : lk_idx_i;
  assign ram_wdata_o     = ram_we_o && state_q == UPD_WR ? {ram_rdata_i[HIST_W-2:0], wr_q.taken} : '0;
  assign lk_hist_valid_o = hv_q;
  assign lk_hist_o       = hv_q ? ram_rdata_i : hist_q;
  lht_upd_fifo #(.DEPTH(Q_DEPTH), .T(upd_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (up_in),
    .pop_i   (upd_go),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (q_count_o)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      if (CLEAR_ON_RESET) state_q <= CLEAR;
      else state_q <= IDLE;
      clr_q    <= '0;
      starve_q <= '0;
      wr_q     <= '0;
      hv_q     <= 1'b0;
      hist_q   <= '0;
    end else begin
      hv_q   <= lk_go;
      hist_q <= lk_hist_o;
      case (state_q)
        CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (&clr_q) state_q <= IDLE;
        end
        UPD_WR: state_q <= IDLE;
        IDLE:
          if (upd_go) begin
            state_q  <= UPD_WR;
            wr_q     <= head;
            starve_q <= '0;
          end else if (lk_go) starve_q <= empty ? '0 : starve_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lht_access_ctrl.sv
// tb_lht_access_ctrl: directed and random checks of the LHT controller against a queue/table reference model
module tb_lht_access_ctrl;
  localparam int IW = 10, HW = 10, QD = 4, MS = 8, N = 1024;
  localparam bit CLR = 1'b1;
  logic clk = 0, rst_n = 0, lk_valid = 0, up_valid = 0, up_taken = 0;
  logic [IW-1:0] lk_idx = '0, up_idx = '0;
  logic lk_ready, lk_hist_valid, up_ready, ram_en, ram_we;
  logic [HW-1:0] lk_hist, ram_wdata, ram_rdata;
  logic [IW-1:0] ram_addr;
  logic [2:0] q_count;
  lht_access_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .lk_valid_i(lk_valid), .lk_idx_i(lk_idx), .lk_ready_o(lk_ready),
    .lk_hist_valid_o(lk_hist_valid), .lk_hist_o(lk_hist), .up_valid_i(up_valid), .up_idx_i(up_idx),
    .up_taken_i(up_taken), .up_ready_o(up_ready), .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .q_count_o(q_count)
  );
  always #5 clk = ~clk;
  logic [HW-1:0] mem [N];
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  typedef struct {logic [IW-1:0] idx; bit taken;} upd_t;
  upd_t m_q[$];
  logic [HW-1:0] shadow [N];
  bit m_clearing = 1, m_wr = 0, m_hv = 0;
  int m_clr = 0, m_starve = 0;
  upd_t m_wr_u;
  logic [HW-1:0] m_h = '0;
  bit e_lk_ready, e_up_ready, e_en, e_we, e_hv;
  logic [IW-1:0] e_addr;
  logic [HW-1:0] e_wd, e_h;
  logic [2:0] e_qc;
  logic o_lk_ready, o_up_ready, o_en, o_we, o_hv;
  logic [IW-1:0] o_addr;
  logic [HW-1:0] o_wd, o_h;
  logic [2:0] o_qc;
  int n_checks = 0, n_fail = 0;

  // One clock: derive expectations from the model, sample the DUT at negedge, advance the model at posedge
  task automatic tick();
    bit pop_u;
    upd_t u;
    int sz;
    @(negedge clk);
    sz = m_q.size();
    pop_u = 0;
    e_lk_ready = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
    e_up_ready = rst_n && !m_clearing && sz < QD;
    e_hv = m_hv; e_h = m_h; e_qc = 3'(sz);
    if (rst_n) begin
      if (m_clearing) begin
        e_en = 1; e_we = 1; e_addr = IW'(m_clr);
      end else if (m_wr) begin
        e_en = 1; e_we = 1; e_addr = m_wr_u.idx;
        e_wd = {shadow[m_wr_u.idx][HW-2:0], m_wr_u.taken};
      end else if (sz > 0 && (sz == QD || !lk_valid || m_starve == MS)) begin
        e_en = 1; e_addr = m_q[0].idx; pop_u = 1;
      end else if (lk_valid) begin
        e_lk_ready = 1; e_en = 1; e_addr = lk_idx;
      end
    end
    o_lk_ready = lk_ready; o_up_ready = up_ready; o_en = ram_en; o_we = ram_we;
    o_addr = ram_addr; o_wd = ram_wdata; o_hv = lk_hist_valid; o_h = lk_hist; o_qc = q_count;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete(); m_clearing = CLR; m_clr = 0; m_starve = 0; m_wr = 0; m_hv = 0; m_h = '0;
    end else begin
      if (m_clearing) begin
        shadow[m_clr] = '0; m_clr++; m_clearing = m_clr < N;
      end
      if (m_wr) begin
        shadow[m_wr_u.idx] = e_wd; m_wr = 0;
      end
      if (pop_u) begin
        m_wr_u = m_q.pop_front(); m_wr = 1; m_starve = 0;
      end
      if (e_lk_ready) begin
        m_h = shadow[lk_idx]; m_starve = sz > 0 ? m_starve + 1 : 0;
      end
      m_hv = e_lk_ready;
      if (up_valid && e_up_ready) begin
        u.idx = up_idx; u.taken = up_taken; m_q.push_back(u);
      end
    end
    #1;
  endtask

  task automatic drain();
    lk_valid = 0; up_valid = 0;
    for (int i = 0; i < 40 && (m_q.size() > 0 || m_wr); i++) tick();
  endtask

  task automatic do_lookup(input logic [IW-1:0] idx, output bit g, output logic [HW-1:0] h);
    lk_valid = 1; lk_idx = idx; up_valid = 0;
    tick();
    g = o_lk_ready;
    lk_valid = 0;
    tick();
    h = o_h;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (o_en !== 0 || o_lk_ready !== 0 || o_up_ready !== 0 || o_hv !== 0 || o_qc !== 0) begin
        n_fail++;
        $display("FAIL reset_outs cyc %0d: got en=%b lk_rdy=%b up_rdy=%b hv=%b qc=%0d, want all 0", i, o_en, o_lk_ready, o_up_ready, o_hv, o_qc);
      end
    end
  endtask

  task automatic test_clear();
    rst_n = 1; lk_valid = 1; lk_idx = 5; up_valid = 1; up_idx = 7;
    for (int i = 0; i < N; i++) begin
      tick();
      n_checks++;
      if (o_lk_ready !== 0 || o_up_ready !== 0) begin
        n_fail++;
        $display("FAIL clr_ready cyc %0d: got lk_rdy=%b up_rdy=%b want 0 0", i, o_lk_ready, o_up_ready);
      end
      n_checks++;
      if (o_en !== 1 || o_we !== 1 || o_addr !== IW'(i) || o_wd !== '0) begin
        n_fail++;
        $display("FAIL clr_write cyc %0d: got en=%b we=%b addr=%0d wd=%h want 1 1 %0d 0", i, o_en, o_we, o_addr, o_wd, i);
      end
    end
    up_valid = 0;
    tick();
    n_checks++;
    if (o_lk_ready !== 1 || o_we !== 0 || o_addr !== 5 || o_qc !== 0) begin
      n_fail++;
      $display("FAIL first_lookup: got rdy=%b we=%b addr=%0d qc=%0d want 1 0 5 0", o_lk_ready, o_we, o_addr, o_qc);
    end
    lk_valid = 0;
    tick();
    n_checks++;
    if (o_hv !== 1 || o_h !== '0) begin
      n_fail++;
      $display("FAIL first_hist: got hv=%b hist=%b want 1 0", o_hv, o_h);
    end
  endtask

  task automatic test_update_seq();
    bit tk [15] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    bit g;
    logic [HW-1:0] h;
    for (int i = 0; i < 15; i++) begin
      up_valid = 1; up_idx = 5; up_taken = tk[i];
      tick();
      n_checks++;
      if (o_up_ready !== 1) begin
        n_fail++;
        $display("FAIL upd_push %0d: got up_ready=%b want 1", i, o_up_ready);
      end
      drain();
      if (i == 2 || i == 14) begin
        do_lookup(5, g, h);
        n_checks++;
        if (g !== 1 || h !== (i == 2 ? 10'b0000000011 : 10'b0000001111)) begin
          n_fail++;
          $display("FAIL upd_hist after %0d: got grant=%b hist=%b want 1 %b", i + 1, g, h,
                   i == 2 ? 10'b0000000011 : 10'b0000001111);
        end
      end
    end
  endtask

  task automatic test_starve();
    int grants = 0;
    bit done = 0;
    logic [IW-1:0] ui;
    lk_valid = 1; lk_idx = IW'($urandom_range(0, 15));
    tick();
    ui = IW'($urandom_range(0, 15));
    up_valid = 1; up_idx = ui; up_taken = 1;
    tick();
    up_valid = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (o_lk_ready === 1) grants++;
      else done = 1;
    end
    n_checks++;
    if (grants != MS || !done) begin
      n_fail++;
      $display("FAIL starve_grants: got %0d lookups want %0d", grants, MS);
    end
    n_checks++;
    if (o_en !== 1 || o_we !== 0 || o_addr !== ui) begin
      n_fail++;
      $display("FAIL starve_read: got en=%b we=%b addr=%0d want 1 0 %0d", o_en, o_we, o_addr, ui);
    end
    tick();
    n_checks++;
    if (o_lk_ready !== 0 || o_we !== 1 || o_addr !== ui) begin
      n_fail++;
      $display("FAIL starve_write: got rdy=%b we=%b addr=%0d want 0 1 %0d", o_lk_ready, o_we, o_addr, ui);
    end
    tick();
    n_checks++;
    if (o_lk_ready !== 1) begin
      n_fail++;
      $display("FAIL starve_resume: got lk_ready=%b want 1", o_lk_ready);
    end
    lk_valid = 0;
  endtask

  task automatic test_full();
    int qseq [8] = '{4, 3, 3, 2, 2, 1, 1, 0};
    bit g;
    logic [HW-1:0] h;
    lk_valid = 1; lk_idx = 3;
    for (int i = 0; i < 4; i++) begin
      up_valid = 1; up_idx = IW'(20 + i); up_taken = i[0];
      tick();
      n_checks++;
      if (o_up_ready !== 1) begin
        n_fail++;
        $display("FAIL full_push %0d: got up_ready=%b want 1", i, o_up_ready);
      end
    end
    up_valid = 1; up_idx = 40;
    tick();
    n_checks++;
    if (o_qc !== 4 || o_up_ready !== 0 || o_lk_ready !== 0) begin
      n_fail++;
      $display("FAIL full_state: got qc=%0d up_rdy=%b lk_rdy=%b want 4 0 0", o_qc, o_up_ready, o_lk_ready);
    end
    up_valid = 0; lk_valid = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      n_checks++;
      if (o_qc !== 3'(qseq[i]) || o_lk_ready !== 0) begin
        n_fail++;
        $display("FAIL full_drain cyc %0d: got qc=%0d lk_rdy=%b want %0d 0", i, o_qc, o_lk_ready, qseq[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_lookup(IW'(20 + i), g, h);
      n_checks++;
      if (g !== 1 || h !== HW'(i % 2)) begin
        n_fail++;
        $display("FAIL full_hist idx %0d: got grant=%b hist=%b want 1 %0d", 20 + i, g, h, i % 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit g;
    logic [HW-1:0] h;
    lk_valid = 0;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1; up_idx = IW'(30 + i); up_taken = 1;
      tick();
    end
    up_valid = 0;
    tick();
    n_checks++;
    if (o_en !== 1 || o_we !== 0 || o_addr !== 31) begin
      n_fail++;
      $display("FAIL rm_pop: got en=%b we=%b addr=%0d want 1 0 31", o_en, o_we, o_addr);
    end
    rst_n = 0;
    tick();
    n_checks++;
    if (o_en !== 0) begin
      n_fail++;
      $display("FAIL rm_wr_abandon: got ram_en=%b want 0", o_en);
    end
    tick();
    n_checks++;
    if (o_en !== 0 || o_qc !== 0 || o_up_ready !== 0) begin
      n_fail++;
      $display("FAIL rm_after: got en=%b qc=%0d up_rdy=%b want 0 0 0", o_en, o_qc, o_up_ready);
    end
    rst_n = 1;
    for (int i = 0; i < 100; i++) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    n_checks++;
    if (o_en !== 1 || o_we !== 1 || o_addr !== 0) begin
      n_fail++;
      $display("FAIL rm_clr_restart: got en=%b we=%b addr=%0d want 1 1 0", o_en, o_we, o_addr);
    end
    for (int i = 1; i < N + 5 && m_clearing; i++) begin
      tick();
      n_checks++;
      if (o_addr !== IW'(i) || o_lk_ready !== 0) begin
        n_fail++;
        $display("FAIL rm_clr_addr: got addr=%0d lk_rdy=%b want %0d 0", o_addr, o_lk_ready, i);
      end
    end
    for (int i = 30; i < 32; i++) begin
      do_lookup(IW'(i), g, h);
      n_checks++;
      if (g !== 1 || h !== '0) begin
        n_fail++;
        $display("FAIL rm_cleared idx %0d: got grant=%b hist=%b want 1 0", i, g, h);
      end
    end
  endtask

  task automatic test_random();
    bit g;
    logic [HW-1:0] h;
    for (int c = 0; c < 10000; c++) begin
      lk_valid = ($urandom % 4) != 0; lk_idx = IW'($urandom_range(0, 15));
      up_valid = 1'($urandom % 2); up_idx = IW'($urandom_range(0, 15)); up_taken = 1'($urandom % 2);
      tick();
      n_checks++;
      if (o_lk_ready !== e_lk_ready || o_up_ready !== e_up_ready) begin
        n_fail++;
        $display("FAIL rnd_ready cyc %0d: got lk=%b up=%b want %b %b", c, o_lk_ready, o_up_ready, e_lk_ready, e_up_ready);
      end
      n_checks++;
      if (o_en !== e_en || o_we !== e_we || (e_en && o_addr !== e_addr) || (e_we && o_wd !== e_wd)) begin
        n_fail++;
        $display("FAIL rnd_ram cyc %0d: got en=%b we=%b addr=%0d wd=%b want %b %b %0d %b", c, o_en, o_we, o_addr, o_wd, e_en, e_we, e_addr, e_wd);
      end
      n_checks++;
      if (o_hv !== e_hv || o_h !== e_h || o_qc !== e_qc) begin
        n_fail++;
        $display("FAIL rnd_out cyc %0d: got hv=%b hist=%b qc=%0d want %b %b %0d", c, o_hv, o_h, o_qc, e_hv, e_h, e_qc);
      end
    end
    drain();
    for (int i = 0; i < 16; i++) begin
      do_lookup(IW'(i), g, h);
      n_checks++;
      if (g !== 1 || h !== shadow[i]) begin
        n_fail++;
        $display("FAIL rnd_final idx %0d: got grant=%b hist=%b want 1 %b", i, g, h, shadow[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_update_seq();
    test_starve();
    test_full();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
